// File: rtl/bus_pkg.sv
// bus_pkg: shared FSM/owner types, default IO boundary and wait-state helper
package bus_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} busState;
  typedef enum logic {CPU, DMA} busOwner;
  localparam logic [7:0] DEFAULT_IO_BASE = 8'hFD;
  function automatic logic [1:0] waitCycles(
    input logic [7:0] address,
    input logic [7:0] ioBase,
    input logic [1:0] memWait,
    input logic [1:0] ioWait
  );
    return (address >= ioBase) ? ioWait : memWait;
  endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin tie-break, favours the requester not served last
module rr_arbiter2
  import bus_pkg::*;
(
  input  logic    cpuReq,
  input  logic    dmaReq,
  input  busOwner lastOwner,
  output busOwner winner
);
  // On a tie hand the bus to whoever did not own it last; otherwise to the sole requester
  always_comb winner = (cpuReq && dmaReq) ? ((lastOwner == CPU) ? DMA : CPU) : (cpuReq ? CPU : DMA);
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one memory/IO bus between CPU and DMA with per-region wait states
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int         MEM_WAIT = 0,
  parameter int         IO_WAIT  = 1,
  parameter logic [7:0] IO_BASE  = DEFAULT_IO_BASE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpuReq,
  input  logic       cpuWrite,
  input  logic [7:0] cpuAddress,
  input  logic [7:0] cpuWdata,
  input  logic       dmaReq,
  input  logic       dmaWrite,
  input  logic [7:0] dmaAddress,
  input  logic [7:0] dmaWdata,
  output logic       cpuGrant,
  output logic       cpuDone,
  output logic       dmaGrant,
  output logic       dmaDone,
  output logic [7:0] busAddress,
  output logic [7:0] busWdata,
  output logic       busWriteEnable,
  input  logic [7:0] busRdata,
  output logic [7:0] rdata
);
  busState    state;
  busOwner    owner;
  busOwner    lastOwner;
  busOwner    winner;
  logic       isWrite;
  logic [1:0] waitCnt;
  logic       selWrite;
  logic [7:0] selAddress;
  logic [7:0] selWdata;
  logic [1:0] selWait;

  rr_arbiter2 tieBreak (
    .cpuReq   (cpuReq),
    .dmaReq   (dmaReq),
    .lastOwner(lastOwner),
    .winner   (winner)
  );

  // Gather the winning requester's access and its wait-state count
  always_comb begin
    selWrite   = (winner == CPU) ? cpuWrite : dmaWrite;
    selAddress = (winner == CPU) ? cpuAddress : dmaAddress;
    selWdata   = (winner == CPU) ? cpuWdata : dmaWdata;
    selWait    = waitCycles(selAddress, IO_BASE, 2'(MEM_WAIT), 2'(IO_WAIT));
  end

  // Access sequencer: the access is latched on grant so a dropped request still completes
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      owner          <= CPU;
      lastOwner      <= DMA;
      isWrite        <= 1'b0;
      waitCnt        <= 2'd0;
      cpuGrant       <= 1'b0;
      dmaGrant       <= 1'b0;
      cpuDone        <= 1'b0;
      dmaDone        <= 1'b0;
      busAddress     <= 8'h00;
      busWdata       <= 8'h00;
      busWriteEnable <= 1'b0;
      rdata          <= 8'h00;
    end else begin
      case (state)
        IDLE: if (cpuReq || dmaReq) begin
          state          <= ACCESS;
          owner          <= winner;
          cpuGrant       <= winner == CPU;
          dmaGrant       <= winner == DMA;
          isWrite        <= selWrite;
          busAddress     <= selAddress;
          busWdata       <= selWdata;
          waitCnt        <= selWait;
          busWriteEnable <= selWrite && selWait == 2'd0;
        end
        ACCESS: if (waitCnt != 2'd0) begin
          waitCnt        <= waitCnt - 2'd1;
          busWriteEnable <= isWrite && waitCnt == 2'd1;
        end else begin
          state          <= DONE;
          busWriteEnable <= 1'b0;
          busAddress     <= 8'h00;
          busWdata       <= 8'h00;
          rdata          <= isWrite ? rdata : busRdata;
          cpuDone        <= owner == CPU;
          dmaDone        <= owner == DMA;
        end
        DONE: begin
          state     <= IDLE;
          lastOwner <= owner;
          cpuGrant  <= 1'b0;
          dmaGrant  <= 1'b0;
          cpuDone   <= 1'b0;
          dmaDone   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scoreboard bench for the CPU/DMA bus arbiter
module tb_bus_arbiter;
  logic clk = 0, reset = 1;
  logic cpuReq = 0, cpuWrite = 0, dmaReq = 0, dmaWrite = 0;
  logic [7:0] cpuAddress = 0, cpuWdata = 0, dmaAddress = 0, dmaWdata = 0;
  logic cpuGrant, cpuDone, dmaGrant, dmaDone, busWriteEnable;
  logic [7:0] busAddress, busWdata, busRdata, rdata;
  logic sReset = 1, sCpuReq = 0, sCpuWrite = 0;
  logic [7:0] sCpuAddress = 0, sCpuWdata = 0;
  logic sCpuGrant, sCpuDone, sDmaGrant, sDmaDone, sBusWriteEnable;
  logic [7:0] sBusAddress, sBusWdata, sBusRdata, sRdata;

  typedef struct {bit dma; logic [7:0] rdata; int cyc;} expEntry;
  expEntry sb[$];
  int assertCount = 0, failCount = 0, cyc = 0;
  int weCount = 0, sWeCount = 0, sDoneCount = 0;

  assign busRdata  = busAddress ^ 8'hB5;
  assign sBusRdata = sBusAddress ^ 8'hB5;

  bus_arbiter dut (
    .clk(clk), .reset(reset),
    .cpuReq(cpuReq), .cpuWrite(cpuWrite), .cpuAddress(cpuAddress), .cpuWdata(cpuWdata),
    .dmaReq(dmaReq), .dmaWrite(dmaWrite), .dmaAddress(dmaAddress), .dmaWdata(dmaWdata),
    .cpuGrant(cpuGrant), .cpuDone(cpuDone), .dmaGrant(dmaGrant), .dmaDone(dmaDone),
    .busAddress(busAddress), .busWdata(busWdata), .busWriteEnable(busWriteEnable),
    .busRdata(busRdata), .rdata(rdata)
  );

  bus_arbiter #(.IO_WAIT(3)) dutSlow (
    .clk(clk), .reset(sReset),
    .cpuReq(sCpuReq), .cpuWrite(sCpuWrite), .cpuAddress(sCpuAddress), .cpuWdata(sCpuWdata),
    .dmaReq(1'b0), .dmaWrite(1'b0), .dmaAddress(8'h00), .dmaWdata(8'h00),
    .cpuGrant(sCpuGrant), .cpuDone(sCpuDone), .dmaGrant(sDmaGrant), .dmaDone(sDmaDone),
    .busAddress(sBusAddress), .busWdata(sBusWdata), .busWriteEnable(sBusWriteEnable),
    .busRdata(sBusRdata), .rdata(sRdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic pushExp(input bit dma, input logic [7:0] data, input int doneCyc);
    expEntry e;
    e.dma = dma;
    e.rdata = data;
    e.cyc = doneCyc;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    expEntry e;
    checkVal("grantExcl", cpuGrant & dmaGrant, 0);
    checkVal("doneExcl", cpuDone & dmaDone, 0);
    if (busWriteEnable) weCount++;
    if (sBusWriteEnable) sWeCount++;
    if (sCpuDone) sDoneCount++;
    if (cpuDone || dmaDone) begin
      if (sb.size() == 0) checkVal("unexpectedDone", sb.size(), 1);
      else begin
        e = sb.pop_front();
        checkVal("doneOwner", dmaDone, e.dma);
        checkVal("doneCycle", cyc, e.cyc);
        checkVal("doneRdata", rdata, e.rdata);
        checkVal("doneGrant", e.dma ? dmaGrant : cpuGrant, 1);
      end
    end
  end

  logic [7:0] tblAddr [4] = '{8'h00, 8'hFC, 8'hFD, 8'hFF};
  int         tblWait [4] = '{0, 0, 1, 1};

  initial begin
    int c, weBefore;
    cpuReq = 1; cpuAddress = 8'h20;
    dmaReq = 1; dmaAddress = 8'h30;
    repeat (2) @(negedge clk);
    checkVal("rstGrant", {cpuGrant, dmaGrant}, 0);
    checkVal("rstDone", {cpuDone, dmaDone}, 0);
    checkVal("rstWe", busWriteEnable, 0);
    checkVal("rstAddr", busAddress, 0);
    checkVal("rstWdata", busWdata, 0);
    checkVal("rstRdata", rdata, 0);
    reset = 0; sReset = 0; c = cyc;
    pushExp(0, 8'h95, c + 2);
    pushExp(1, 8'h85, c + 5);
    pushExp(0, 8'h95, c + 8);
    pushExp(1, 8'h85, c + 11);
    repeat (11) @(negedge clk);
    cpuReq = 0; dmaReq = 0;
    @(negedge clk);
    c = cyc;
    cpuWrite = 0; cpuAddress = 8'h10; cpuReq = 1;
    pushExp(0, 8'hA5, c + 2);
    @(negedge clk);
    checkVal("t1CpuGrant", cpuGrant, 1);
    checkVal("t1DmaGrant", dmaGrant, 0);
    checkVal("t1Addr", busAddress, 8'h10);
    @(negedge clk);
    cpuReq = 0;
    @(negedge clk);
    c = cyc; weBefore = weCount;
    dmaWrite = 1; dmaAddress = 8'hFE; dmaWdata = 8'h3C; dmaReq = 1;
    pushExp(1, 8'hA5, c + 3);
    @(negedge clk);
    checkVal("t2Grant", dmaGrant, 1);
    checkVal("t2CpuGrant", cpuGrant, 0);
    checkVal("t2WeEarly", busWriteEnable, 0);
    checkVal("t2Addr", busAddress, 8'hFE);
    @(negedge clk);
    checkVal("t2We", busWriteEnable, 1);
    checkVal("t2Wdata", busWdata, 8'h3C);
    @(negedge clk);
    checkVal("t2WeLate", busWriteEnable, 0);
    dmaReq = 0; dmaWrite = 0;
    @(negedge clk);
    checkVal("idleGrant", {cpuGrant, dmaGrant}, 0);
    checkVal("idleAddr", busAddress, 0);
    checkVal("idleWdata", busWdata, 0);
    checkVal("t2WeCount", weCount - weBefore, 1);
    for (int i = 0; i < 4; i++) begin
      c = cyc;
      cpuAddress = tblAddr[i]; cpuReq = 1;
      pushExp(0, tblAddr[i] ^ 8'hB5, c + 2 + tblWait[i]);
      repeat (2 + tblWait[i]) @(negedge clk);
      cpuReq = 0;
      @(negedge clk);
    end
    c = cyc;
    cpuAddress = 8'h40; cpuReq = 1;
    pushExp(0, 8'h40 ^ 8'hB5, c + 2);
    @(negedge clk);
    checkVal("t4Grant", cpuGrant, 1);
    cpuReq = 0;
    dmaWrite = 0; dmaAddress = 8'h50; dmaReq = 1;
    pushExp(1, 8'h50 ^ 8'hB5, c + 5);
    repeat (4) @(negedge clk);
    dmaReq = 0;
    @(negedge clk);
    sCpuWrite = 1; sCpuAddress = 8'hFD; sCpuWdata = 8'h77; sCpuReq = 1;
    @(negedge clk);
    checkVal("t5Grant", sCpuGrant, 1);
    checkVal("t5Addr", sBusAddress, 8'hFD);
    @(negedge clk);
    checkVal("t5WeEarly", sBusWriteEnable, 0);
    sReset = 1; sCpuReq = 0;
    @(negedge clk);
    checkVal("t5RstGrant", {sCpuGrant, sDmaGrant}, 0);
    checkVal("t5RstDone", {sCpuDone, sDmaDone}, 0);
    checkVal("t5RstWe", sBusWriteEnable, 0);
    checkVal("t5RstAddr", sBusAddress, 0);
    checkVal("t5RstWdata", sBusWdata, 0);
    checkVal("t5RstRdata", sRdata, 0);
    sReset = 0;
    repeat (6) @(negedge clk);
    checkVal("t5WeCount", sWeCount, 0);
    checkVal("t5DoneCount", sDoneCount, 0);
    repeat (3) @(negedge clk);
    checkVal("sbEmpty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 0, extra wait cycles for RAM accesses (0..3).
REQ-002 SHALL have parameter IO_WAIT, default 1, extra wait cycles for IO accesses (0..3).
REQ-003 SHALL have parameter IO_BASE, default 8'hFD, lowest IO-mapped address; addresses >= IO_BASE are IO.
REQ-004 Ports (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpuReq / dmaReq  in  1  access request, held until matching Done.
- cpuWrite / dmaWrite  in  1  1=write, 0=read; held with Req.
- cpuAddress / dmaAddress  in  8  access address; held with Req.
- cpuWdata / dmaWdata  in  8  write data; held with Req.
- cpuGrant / dmaGrant  out  1  requester owns the bus.
- cpuDone / dmaDone  out  1  one-cycle completion pulse.
- busAddress  out  8  address to memory/IO decoder.
- busWdata  out  8  write data to memory/IO.
- busWriteEnable  out  1  write strobe to decoder.
- busRdata  in  8  read data from memory/IO, valid combinationally for busAddress.
- rdata  out  8  captured read data, valid while Done is high and held until the next capture.

Function
REQ-005 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-006 IDLE: with no request, all grants 0, busAddress=0, busWdata=0, busWriteEnable=0.
REQ-007 IDLE with a request at edge N: owner latched, grant high from cycle N+1, state goes to ACCESS.
REQ-008 Both requests in IDLE: grant goes to the requester not served last (round-robin); lastOwner resets to DMA, so the CPU wins the first tie.
REQ-009 ACCESS: busAddress and busWdata driven from the owner's inputs; lasts 1+W cycles, where W=IO_WAIT if address>=IO_BASE, else MEM_WAIT.
REQ-010 Wait counter is 2 bits, loaded with W on entry to ACCESS, and decrements each ACCESS cycle; ACCESS ends when it is 0.
REQ-011 busWriteEnable SHALL be high for exactly one cycle (the final ACCESS cycle), and only if the owner's Write=1.
REQ-012 On the final ACCESS cycle, rdata captures busRdata if the access is a read; writes leave rdata unchanged.
REQ-013 DONE: lasts one cycle; owner's Done=1 and Grant=1; lastOwner updated; next state IDLE.
REQ-014 Total latency from request sample to Done = 2+W cycles; minimum back-to-back period = 3+W cycles.
REQ-015 Requests are never pre-empted; the other requester waits until IDLE.
REQ-016 A request dropped mid-transaction SHALL NOT abort it; it completes and Done still pulses.
REQ-017 Grant and Done of the non-owner SHALL remain 0 at all times.
REQ-018 Address wrap: 8'hFF is IO and 8'h00 is RAM; no address arithmetic is performed.

Reset
REQ-019 When reset=1 at an edge: state=IDLE, grants=0, Done=0, busWriteEnable=0, busAddress=0, busWdata=0, rdata=0, wait counter=0, lastOwner=DMA.
REQ-020 Reset during ACCESS SHALL abort the transaction with no write strobe in the following cycle and no Done pulse.

Structure
REQ-021 A shared package bus_pkg SHALL hold the state enum (IDLE/ACCESS/DONE), the owner enum (CPU/DMA), and the default IO_BASE constant.
REQ-022 The tie-break SHALL be a sub-module rr_arbiter2 (inputs: two requests and lastOwner; output: winner); it is purely combinational.

Verification
REQ-023 Single CPU read, addr 8'h10, MEM_WAIT=0: cpuGrant at N+1, cpuDone at N+2, rdata = busRdata value (e.g. 8'hA5).
REQ-024 DMA write, addr 8'hFE, data 8'h3C, IO_WAIT=1: busWriteEnable is high for one cycle only (cycle N+2) with busWdata=8'h3C; dmaDone at N+3.
REQ-025 Both requesting continuously from reset: grant order CPU, DMA, CPU, DMA; each Done is separated by 3 cycles.
REQ-026 Reset asserted during a CPU write in ACCESS with IO_WAIT=3 (address 8'hFD): no busWriteEnable or cpuDone; all outputs 0 in the next cycle.
REQ-027 CPU drops cpuReq one cycle after grant: cpuDone still pulses once; the DMA request pending since grant is served next.
